// File: rtl/jk_cmd_driver_if.sv
// jk_cmd_driver_if: valid/ready command channel into jk_cmd_driver.
// master drives cmd_valid/cmd_op/cmd_len, slave returns cmd_ready.
interface jk_cmd_driver_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid, cmd_op, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: queues JK commands and drives J/K of an external JK
// flip-flop for cmd_len cycles each, then checks Q_fb against a prediction.
// Ports: clk, rst_n (async low); cmd (slave: valid/ready/op/len);
// J, K out; Q_fb in; busy, done (pulse), err (sticky), err_clr in.
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    jk_cmd_driver_if.slave cmd,
    output logic           J,
    output logic           K,
    input  logic           Q_fb,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic           err_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] OP_RST = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t state, state_nx;

    logic [CNT_W+1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             empty, full, push, pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;
    logic [1:0]       cur_op;
    logic [CNT_W-1:0] cnt;
    logic             pred_q, pred_valid;
    logic             j_nx, k_nx;
    logic             last_beat;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cmd.cmd_ready = !full;
    assign push = cmd.cmd_valid && !full;
    assign pop  = (state == IDLE) && !empty;
    assign {head_op, head_len} = mem[rd_ptr[PW-1:0]];
    assign busy = (state != IDLE) || !empty;
    assign done = (state == CHECK);
    assign last_beat = (state == DRIVE) && (cnt == CNT_W'(1));

    // Storage needs no reset: empty pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {cmd.cmd_op, cmd.cmd_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!empty) state_nx = DRIVE;
            DRIVE:   if (last_beat) state_nx = CHECK;
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Op encoding maps directly: J = op[1], K = op[0].
    always_comb begin
        j_nx = 1'b0;
        k_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    j_nx = head_op[1];
                    k_nx = head_op[0];
                end
            end
            DRIVE: begin
                if (!last_beat) begin
                    j_nx = J;
                    k_nx = K;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            J          <= 1'b0;
            K          <= 1'b0;
            cnt        <= '0;
            cur_op     <= '0;
            pred_q     <= 1'b0;
            pred_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            J <= j_nx;
            K <= k_nx;
            if (pop) begin
                cnt    <= (head_len == '0) ? CNT_W'(1) : head_len;
                cur_op <= head_op;
            end else if (state == DRIVE) begin
                cnt <= cnt - 1'b1;
            end
            // Track what the downstream flop should do with today's J/K.
            unique case ({J, K})
                2'b01:   pred_q <= 1'b0;
                2'b10:   pred_q <= 1'b1;
                2'b11:   pred_q <= ~pred_q;
                default: ;
            endcase
            // Only SET/RESET pin Q to a known value.
            if (last_beat && (cur_op == OP_RST || cur_op == OP_SET))
                pred_valid <= 1'b1;
            // A mismatch wins over a simultaneous clear.
            if (done && pred_valid && (Q_fb != pred_q)) err <= 1'b1;
            else if (err_clr)                           err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb_jk_cmd_driver: scoreboard bench for jk_cmd_driver.
// Stimulus schedules each command on a timeline; monitor checks every cycle.
module tb_jk_cmd_driver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    typedef struct {
        logic [1:0] op;
        int         len;
        int         a;
        int         p;
        int         c;
    } rec_t;

    logic clk = 0;
    logic rst_n = 0;
    logic J, K, busy, done, err;
    logic q_fb = 0;
    logic err_clr = 0;
    logic rand_fb = 0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   last_c = -100;
    int   c_tmp;
    rec_t sb[$];

    logic mq, mvalid, merr;
    logic [1:0] ejk;
    logic edone, ebusy;
    int   fifo_n;

    jk_cmd_driver_if #(.CNT_W(CNT_W)) cmd();

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd),
        .J(J), .K(K), .Q_fb(q_fb),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] jk_of(input logic [1:0] op);
        case (op)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d",
                      name, cyc, act, exp);
    endtask

    // Monitor: expected outputs follow from the scheduled timeline of
    // each command (pop edge p, check edge c) and a simple Q model.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            chk("rst_j", J, 0);
            chk("rst_k", K, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd.cmd_ready, 1);
            mq = 0;
            mvalid = 0;
            merr = 0;
        end else begin
            fifo_n = 0;
            ejk = 2'b00;
            edone = 0;
            ebusy = 0;
            foreach (sb[i])
                if (sb[i].a <= cyc && sb[i].p > cyc) fifo_n++;
            if (sb.size() > 0 && sb[0].p <= cyc) begin
                ebusy = 1;
                if (cyc < sb[0].c) ejk = jk_of(sb[0].op);
                edone = (cyc == sb[0].c);
            end
            if (fifo_n > 0) ebusy = 1;
            chk("j", J, ejk[1]);
            chk("k", K, ejk[0]);
            chk("done", done, edone);
            chk("busy", busy, ebusy);
            chk("cmd_ready", cmd.cmd_ready, fifo_n < DEPTH);
            chk("err", err, merr);
            if (edone) begin
                case (sb[0].op)
                    2'd1: begin mq = 0; mvalid = 1; end
                    2'd2: begin mq = 1; mvalid = 1; end
                    2'd3: mq = mq ^ (sb[0].len % 2 == 1);
                    default: ;
                endcase
                if (mvalid && q_fb != mq) merr = 1;
                else if (err_clr)         merr = 0;
                void'(sb.pop_front());
            end else if (err_clr) begin
                merr = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_fb) begin
            q_fb = 1'($urandom_range(0, 1));
            err_clr = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic push(input logic [1:0] op, input int len,
                        output int c_out);
        int n;
        rec_t r;
        n = 0;
        cmd.cmd_valid = 1;
        cmd.cmd_op = op;
        cmd.cmd_len = len[CNT_W-1:0];
        while (!cmd.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd.cmd_ready) begin
            $display("FAIL push_timeout cycle %0d: got ready 0 expected 1", cyc);
            $fatal(1);
        end
        r.op = op;
        r.len = (len == 0) ? 1 : len;
        r.a = cyc + 1;
        r.p = (r.a + 1 > last_c + 2) ? r.a + 1 : last_c + 2;
        r.c = r.p + r.len;
        last_c = r.c;
        c_out = r.c;
        sb.push_back(r);
        tick();
        cmd.cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        if (sb.size() > 0) begin
            $display("FAIL idle_timeout cycle %0d: got %0d pending expected 0",
                     cyc, sb.size());
            $fatal(1);
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        sb.delete();
        cmd.cmd_valid = 0;
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        last_c = -100;
    endtask

    initial begin
        cmd.cmd_valid = 0;
        cmd.cmd_op = 0;
        cmd.cmd_len = 0;
        do_reset();

        // SET len 2 with matching Q
        q_fb = 1;
        push(2'd2, 2, c_tmp);
        wait_idle();
        // TOGGLE len 3: prediction 0, Q 0 matches
        q_fb = 0;
        push(2'd3, 3, c_tmp);
        wait_idle();
        // HOLD keeps prediction 0; Q 1 flags an error
        q_fb = 1;
        push(2'd0, 1, c_tmp);
        wait_idle();

        // Mismatch together with err_clr keeps err, clear alone drops it
        q_fb = 0;
        push(2'd2, 1, c_tmp);
        while (cyc < c_tmp) tick();
        err_clr = 1;
        tick();
        q_fb = 1;
        tick();
        err_clr = 0;
        wait_idle();

        // TOGGLE len 0 right after reset: one beat, no checking
        do_reset();
        rand_fb = 1;
        push(2'd3, 0, c_tmp);
        wait_idle();
        rand_fb = 0;

        // Burst while idle: fills FIFO, extra command waits for a pop
        for (int i = 0; i < 6; i++) push(2'(i % 4), 8, c_tmp);
        wait_idle();

        // Reset mid-DRIVE with two queued: all discarded
        do_reset();
        push(2'd1, 8, c_tmp);
        push(2'd2, 2, c_tmp);
        push(2'd3, 3, c_tmp);
        repeat (3) tick();
        sb.delete();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        last_c = -100;
        repeat (30) tick();

        // Random traffic
        rand_fb = 1;
        for (int i = 0; i < 60; i++) begin
            push(2'($urandom_range(0, 3)), $urandom_range(0, 6), c_tmp);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        rand_fb = 0;
        err_clr = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
